// File: rtl/hilo_muldiv_unit_if.sv
// Operand, control and HI/LO result bundle between the execute-stage
// controller (master) and the multiply/divide unit (slave).
interface hilo_muldiv_unit_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic [1:0]        op;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              mthi;
  logic              mtlo;
  logic              busy;
  logic              done;
  logic              div_by_zero;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output start, op, rs_data, rt_data, mthi, mtlo,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, rs_data, rt_data, mthi, mtlo,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider owning the HI/LO
// registers; one bit per cycle, DATA_W cycles per operation.
module hilo_muldiv_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input logic               clock,
  input logic               reset,
  hilo_muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  state_t              state;
  state_t              state_next;
  logic [CNT_W-1:0]    cnt;
  logic                accept;
  logic                last;
  logic                mt_allowed;

  logic [2*DATA_W-1:0] acc;
  logic [2*DATA_W-1:0] acc_next;
  logic [2*DATA_W-1:0] mul_next;
  logic [2*DATA_W-1:0] div_next;
  logic [2*DATA_W-1:0] product;
  logic [DATA_W:0]     mul_sum;
  logic [DATA_W:0]     div_shift;
  logic [DATA_W:0]     div_diff;
  logic [DATA_W-1:0]   quot;
  logic [DATA_W-1:0]   rem;
  logic [DATA_W-1:0]   res_hi;
  logic [DATA_W-1:0]   res_lo;

  logic [DATA_W-1:0]   b_mag;
  logic [DATA_W-1:0]   a_raw;
  logic [DATA_W-1:0]   hi_q;
  logic [DATA_W-1:0]   lo_q;
  logic                is_div;
  logic                neg_q;
  logic                neg_r;
  logic                b_zero;
  logic                done_q;
  logic                dbz_q;

  logic                op_signed;
  logic                a_neg;
  logic                b_neg;
  logic [DATA_W-1:0]   a_mag_in;
  logic [DATA_W-1:0]   b_mag_in;

  // op[0]==0 selects the signed flavours (MULT, DIV); magnitudes are formed at launch
  always_comb begin
    op_signed = ~bus.op[0];
    a_neg     = op_signed & bus.rs_data[DATA_W-1];
    b_neg     = op_signed & bus.rt_data[DATA_W-1];
    a_mag_in  = a_neg ? -bus.rs_data : bus.rs_data;
    b_mag_in  = b_neg ? -bus.rt_data : bus.rt_data;
  end

  // acc holds {partial, multiplier} for multiply and {remainder, quotient} for divide
  always_comb begin
    mul_sum   = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, b_mag} : '0);
    mul_next  = {mul_sum, acc[DATA_W-1:1]};
    div_shift = acc[2*DATA_W-1:DATA_W-1];
    div_diff  = div_shift - {1'b0, b_mag};
    if (div_diff[DATA_W]) begin
      div_next = {div_shift[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
    end else begin
      div_next = {div_diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
    end
    acc_next = is_div ? div_next : mul_next;
  end

  always_comb begin
    product = neg_q ? -acc_next : acc_next;
    quot    = acc_next[DATA_W-1:0];
    rem     = acc_next[2*DATA_W-1:DATA_W];
    res_hi  = product[2*DATA_W-1:DATA_W];
    res_lo  = product[DATA_W-1:0];
    if (is_div) begin
      if (b_zero) begin
        res_hi = a_raw;
        res_lo = '1;
      end else begin
        res_hi = neg_r ? -rem : rem;
        res_lo = neg_q ? -quot : quot;
      end
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (cnt == LAST_CNT) begin
          last       = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    mt_allowed = (state != RUN) && !accept;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A launch wins over mthi/mtlo on the same edge; HI/LO only change at completion otherwise
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt    <= '0;
      acc    <= '0;
      b_mag  <= '0;
      a_raw  <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      done_q <= last;
      dbz_q  <= last & is_div & b_zero;
      if (accept) begin
        cnt    <= '0;
        acc    <= {{DATA_W{1'b0}}, a_mag_in};
        b_mag  <= b_mag_in;
        a_raw  <= bus.rs_data;
        is_div <= bus.op[1];
        neg_q  <= a_neg ^ b_neg;
        neg_r  <= a_neg;
        b_zero <= (bus.rt_data == '0);
      end else if (state == RUN) begin
        cnt <= cnt + CNT_W'(1);
        acc <= acc_next;
      end
      if (last) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end else if (mt_allowed) begin
        if (bus.mthi) hi_q <= bus.rs_data;
        if (bus.mtlo) lo_q <= bus.rs_data;
      end
    end
  end

  assign bus.busy        = (state == RUN);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule
